// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO burst arbiter.
// Holds the FSM state encoding and the cyclic round-robin pick function.
// Pure declarations; no logic of its own.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  // Widest requester vector the pick function handles.
  localparam int RR_MAX = 8;

  // Index of the first set request at or after ptr, wrapping over n requesters.
  // Returns 0 when nothing is requested; callers qualify with |req.
  function automatic int rr_pick(input logic [RR_MAX-1:0] req, input int ptr, input int n);
    int win;
    int idx;
    logic found;
    win   = 0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = (ptr + k) % n;
      if (!found && (k < n) && req[3'(idx)]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational cyclic priority encoder over N requesters starting at ptr.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides whether to act on the pick.
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx
);

  logic [RR_MAX-1:0] req_ext;
  int                win;

  // Zero-extend the request vector and search cyclically from ptr.
  always_comb begin
    req_ext          = '0;
    req_ext[N-1:0]   = req;
    win              = rr_pick(req_ext, int'(ptr), N);
    gnt_valid        = |req;
    gnt_idx          = W'(win);
  end

endmodule

// File: rtl/fifo_burst_arbiter.sv
// Round-robin burst scheduler sharing one downstream write port among CH show-ahead FIFOs.
// Latency: grant decided one cycle after eligibility; beats then flow combinationally from the FIFO head.
// Backpressure: m_ready low stalls the burst with no pop; an empty FIFO drops m_valid, never ends a burst early.
module fifo_burst_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int CH        = 4,
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = 8,
  localparam int CW       = $clog2(CH),
  localparam int BW       = $clog2(BURST_LEN) + 1
) (
  input  logic                clk,
  input  logic                rest,
  input  logic                en,
  input  logic                drain,
  input  logic [CH-1:0]       ch_empty,
  input  logic [CH-1:0]       ch_half,
  input  logic [CH*WIDTH-1:0] ch_read_data,
  output logic [CH-1:0]       ch_read,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [WIDTH-1:0]    m_data,
  output logic [CW-1:0]       m_ch,
  output logic                m_start,
  output logic                m_last,
  output logic                busy
);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] grant_q, grant_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [BW-1:0] len_q, len_d;

  logic [CH-1:0] elig;
  logic          pick_vld;
  logic [CW-1:0] pick_idx;
  logic          beat_done;
  logic          last_beat;

  // Drain mode widens eligibility to any non-empty FIFO.
  always_comb begin
    elig = drain ? ~ch_empty : ch_half;
  end

  rr_priority_pick #(
    .N (CH),
    .W (CW)
  ) u_pick (
    .req       (elig),
    .ptr       (rr_ptr_q),
    .gnt_valid (pick_vld),
    .gnt_idx   (pick_idx)
  );

  // Downstream beat signals follow the granted FIFO head directly.
  always_comb begin
    busy             = (state_q == ARB_BURST);
    m_valid          = busy && !ch_empty[grant_q];
    m_data           = ch_read_data[int'(grant_q)*WIDTH +: WIDTH];
    m_ch             = grant_q;
    last_beat        = (beat_q == (len_q - BW'(1)));
    m_start          = busy && (beat_q == '0);
    m_last           = busy && last_beat;
    beat_done        = m_valid && m_ready;
    ch_read          = '0;
    ch_read[grant_q] = beat_done;
  end

  // Next-state: grant in IDLE, count accepted beats in BURST, advance rr pointer past the winner.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    beat_d   = beat_q;
    len_d    = len_q;
    case (state_q)
      ARB_IDLE: begin
        if (en && pick_vld) begin
          grant_d = pick_idx;
          len_d   = drain ? BW'(1) : BW'(BURST_LEN);
          beat_d  = '0;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (beat_done) begin
          beat_d = beat_q + BW'(1);
          if (last_beat) begin
            rr_ptr_d = (grant_q == CW'(CH - 1)) ? '0 : grant_q + CW'(1);
            state_d  = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      beat_q   <= '0;
      len_q    <= BW'(BURST_LEN);
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      beat_q   <= beat_d;
      len_q    <= len_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Bench for fifo_burst_arbiter with four behavioural show-ahead FIFOs of depth 16.
// Expected beat streams come from a queue-based round-robin model of the scheduling rules.
// Directed scenarios plus randomized fills with random downstream readiness.
module tb_fifo_burst_arbiter;

  localparam int CH        = 4;
  localparam int WIDTH     = 32;
  localparam int BURST_LEN = 8;
  localparam int DEPTH     = 16;

  typedef struct packed {
    logic [1:0]       ch;
    logic [WIDTH-1:0] dat;
    logic             st;
    logic             ls;
  } beat_t;

  logic                clk = 1'b0;
  logic                rest;
  logic                en;
  logic                drain;
  logic                m_ready;
  logic [CH-1:0]       ch_empty;
  logic [CH-1:0]       ch_half;
  logic [CH-1:0]       ch_read;
  logic [CH*WIDTH-1:0] ch_read_data;
  logic                m_valid;
  logic [WIDTH-1:0]    m_data;
  logic [1:0]          m_ch;
  logic                m_start;
  logic                m_last;
  logic                busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fifo_burst_arbiter #(
    .CH        (CH),
    .WIDTH     (WIDTH),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk          (clk),
    .rest         (rest),
    .en           (en),
    .drain        (drain),
    .ch_empty     (ch_empty),
    .ch_half      (ch_half),
    .ch_read_data (ch_read_data),
    .ch_read      (ch_read),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_ch         (m_ch),
    .m_start      (m_start),
    .m_last       (m_last),
    .busy         (busy)
  );

  // Behavioural FIFOs
  logic [WIDTH-1:0] fmem [CH][DEPTH];
  int               fcnt [CH];

  for (genvar i = 0; i < CH; i++) begin : g_fifo
    assign ch_empty[i]                   = (fcnt[i] == 0);
    assign ch_half[i]                    = (fcnt[i] >= DEPTH/2);
    assign ch_read_data[i*WIDTH +: WIDTH] = fmem[i][0];
  end

  beat_t beats[$];
  beat_t exp_q[$];
  int    start_cyc[$];
  int    cyc       = 0;
  int    pop_cnt   = 0;
  int    pop_err   = 0;
  int    multi_err = 0;
  int    model_ptr = 0;

  // Sample handshakes at the edge, apply pops just after it.
  always @(posedge clk) begin
    logic [CH-1:0] rd;
    logic          hs;
    beat_t         b;
    cyc++;
    rd   = ch_read;
    hs   = m_valid && m_ready;
    b.ch = m_ch; b.dat = m_data; b.st = m_start; b.ls = m_last;
    #1;
    if ($countones(rd) > 1) multi_err++;
    for (int i = 0; i < CH; i++) begin
      if (rd[i]) begin
        pop_cnt++;
        if (fcnt[i] == 0) pop_err++;
        else begin
          for (int k = 0; k < DEPTH-1; k++) fmem[i][k] = fmem[i][k+1];
          fcnt[i]--;
        end
      end
    end
    if (hs) begin
      beats.push_back(b);
      if (b.st) start_cyc.push_back(cyc);
    end
  end

  task automatic push(input int c, input logic [WIDTH-1:0] v);
    if (fcnt[c] < DEPTH) begin
      fmem[c][fcnt[c]] = v;
      fcnt[c]++;
    end
  endtask

  function automatic bit any_elig();
    for (int c = 0; c < CH; c++)
      if (drain ? (fcnt[c] > 0) : (fcnt[c] >= BURST_LEN)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rest = 1'b0; en = 1'b0; drain = 1'b0; m_ready = 1'b1;
    for (int c = 0; c < CH; c++) fcnt[c] = 0;
    repeat (2) @(negedge clk);
    rest = 1'b1;
    beats.delete(); start_cyc.delete(); pop_cnt = 0; model_ptr = 0;
    @(negedge clk);
  endtask

  // Reference: replay round-robin bursts over a snapshot of the FIFO contents.
  task automatic model_expect(input bit drn);
    logic [WIDTH-1:0] mq [CH][$];
    int ptr;
    int need;
    int g;
    exp_q.delete();
    for (int c = 0; c < CH; c++) begin
      mq[c].delete();
      for (int k = 0; k < fcnt[c]; k++) mq[c].push_back(fmem[c][k]);
    end
    ptr  = model_ptr;
    need = drn ? 1 : BURST_LEN;
    for (int it = 0; it < CH*DEPTH; it++) begin
      g = -1;
      for (int k = 0; k < CH; k++) begin
        int c;
        c = (ptr + k) % CH;
        if (g < 0 && mq[c].size() >= need) g = c;
      end
      if (g < 0) break;
      for (int b = 0; b < need; b++) begin
        beat_t e;
        e.ch  = 2'(g);
        e.dat = mq[g].pop_front();
        e.st  = (b == 0);
        e.ls  = (b == need-1);
        exp_q.push_back(e);
      end
      ptr = (g + 1) % CH;
    end
    model_ptr = ptr;
  endtask

  // rmode: 0 ready held high, 1 random, 2 alternating 1-0-1-0
  task automatic wait_quiet(input int budget, input int rmode, output bit ok);
    bit tog;
    tog = 1'b1;
    ok  = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      case (rmode)
        1:       m_ready = ($urandom_range(0, 3) != 0);
        2:       begin m_ready = tog; tog = ~tog; end
        default: m_ready = 1'b1;
      endcase
      if (!busy && !any_elig()) begin
        ok = 1'b1;
        break;
      end
    end
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rest = 1'b0; en = 1'b1; drain = 1'b0; m_ready = 1'b1;
    for (int c = 0; c < CH; c++) fcnt[c] = 0;
    for (int k = 0; k < BURST_LEN; k++) push(0, 32'h0000_0A00 + k);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, m_valid, m_start, m_last} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b expected 0000", {busy, m_valid, m_start, m_last});
    else n_pass++;
    n_checks++;
    if ({ch_read, m_ch} !== 6'd0) $display("FAIL reset_rd_ch: got %b expected 0", {ch_read, m_ch});
    else n_pass++;
    n_checks++;
    if (pop_cnt !== 0) $display("FAIL reset_pops: got %0d expected 0", pop_cnt);
    else n_pass++;
  endtask

  task automatic test_single_burst();
    bit ok;
    do_reset();
    for (int k = 0; k < 8; k++) push(1, 32'h100 + k);
    model_expect(1'b0);
    en = 1'b1;
    wait_quiet(200, 0, ok);
    n_checks++;
    if (!ok) $display("FAIL t1_timeout: got busy=%b expected idle", busy); else n_pass++;
    n_checks++;
    if (beats.size() != exp_q.size()) $display("FAIL t1_count: got %0d expected %0d", beats.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < exp_q.size() && k < beats.size(); k++) begin
      n_checks++;
      if (beats[k] !== exp_q[k]) $display("FAIL t1_beat%0d: got %h expected %h", k, beats[k], exp_q[k]);
      else n_pass++;
    end
    n_checks++;
    if (fcnt[1] !== 0) $display("FAIL t1_ch1_left: got %0d expected 0", fcnt[1]); else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < DEPTH; k++) push(c, (c << 8) | k);
    model_expect(1'b0);
    en = 1'b1;
    wait_quiet(400, 0, ok);
    n_checks++;
    if (!ok) $display("FAIL t2_timeout: got busy=%b expected idle", busy); else n_pass++;
    n_checks++;
    if (beats.size() != 64) $display("FAIL t2_count: got %0d expected 64", beats.size()); else n_pass++;
    for (int j = 0; j < 5 && (j*8) < beats.size(); j++) begin
      n_checks++;
      if (beats[j*8].ch !== 2'(j % CH)) $display("FAIL t2_order%0d: got ch %0d expected %0d", j, beats[j*8].ch, j % CH);
      else n_pass++;
    end
    for (int k = 0; k < exp_q.size() && k < beats.size(); k++) begin
      n_checks++;
      if (beats[k] !== exp_q[k]) $display("FAIL t2_beat%0d: got %h expected %h", k, beats[k], exp_q[k]);
      else n_pass++;
    end
    for (int j = 0; j + 1 < start_cyc.size(); j++) begin
      n_checks++;
      if (start_cyc[j+1] - start_cyc[j] != BURST_LEN + 1)
        $display("FAIL t2_gap%0d: got %0d cycles expected %0d", j, start_cyc[j+1] - start_cyc[j], BURST_LEN + 1);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    for (int k = 0; k < 8; k++) push(0, 32'h300 + k);
    model_expect(1'b0);
    en = 1'b1;
    wait_quiet(200, 2, ok);
    n_checks++;
    if (!ok) $display("FAIL t3_timeout: got busy=%b expected idle", busy); else n_pass++;
    n_checks++;
    if (pop_cnt != 8) $display("FAIL t3_pops: got %0d expected 8", pop_cnt); else n_pass++;
    n_checks++;
    if (beats.size() != exp_q.size()) $display("FAIL t3_count: got %0d expected %0d", beats.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < exp_q.size() && k < beats.size(); k++) begin
      n_checks++;
      if (beats[k] !== exp_q[k]) $display("FAIL t3_beat%0d: got %h expected %h", k, beats[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_drain();
    bit ok;
    do_reset();
    for (int k = 0; k < 3; k++) push(2, 32'h420 + k);
    drain = 1'b1;
    model_expect(1'b1);
    en = 1'b1;
    wait_quiet(100, 0, ok);
    n_checks++;
    if (!ok) $display("FAIL t4_timeout: got busy=%b expected idle", busy); else n_pass++;
    n_checks++;
    if (beats.size() != 3) $display("FAIL t4_count: got %0d expected 3", beats.size()); else n_pass++;
    for (int k = 0; k < exp_q.size() && k < beats.size(); k++) begin
      n_checks++;
      if (beats[k] !== exp_q[k]) $display("FAIL t4_beat%0d: got %h expected %h", k, beats[k], exp_q[k]);
      else n_pass++;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || beats.size() != 3) $display("FAIL t4_idle: got busy=%b beats=%0d expected 0/3", busy, beats.size());
    else n_pass++;
    drain = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int n;
    int pc;
    do_reset();
    for (int k = 0; k < 8; k++)  push(1, 32'h510 + k);
    for (int k = 0; k < 16; k++) push(2, 32'h520 + k);
    en = 1'b1;
    n  = 0;
    while (beats.size() < 12 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 200) $display("FAIL t5_timeout: got %0d beats expected 12", beats.size()); else n_pass++;
    rest = 1'b0;
    #1;
    n_checks++;
    if ({busy, m_valid, m_start, m_last, ch_read, m_ch} !== 10'd0)
      $display("FAIL t5_async_clear: got %b expected 0", {busy, m_valid, m_start, m_last, ch_read, m_ch});
    else n_pass++;
    pc = pop_cnt;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pop_cnt != pc) $display("FAIL t5_pops_in_reset: got %0d expected %0d", pop_cnt, pc); else n_pass++;
    n_checks++;
    if (fcnt[2] != 12) $display("FAIL t5_ch2_left: got %0d expected 12", fcnt[2]); else n_pass++;
    en = 1'b0;
    for (int k = 0; k < 8; k++) push(0, 32'h500 + k);
    rest = 1'b1;
    @(negedge clk);
    beats.delete();
    model_ptr = 0;
    model_expect(1'b0);
    en = 1'b1;
    wait_quiet(400, 0, ok);
    n_checks++;
    if (!ok) $display("FAIL t5_resume_timeout: got busy=%b expected idle", busy); else n_pass++;
    n_checks++;
    if (beats.size() != 16) $display("FAIL t5_count: got %0d expected 16", beats.size()); else n_pass++;
    n_checks++;
    if (beats.size() == 0 || beats[0].ch !== 2'd0)
      $display("FAIL t5_first_ch: got %0d expected 0", beats.size() == 0 ? -1 : int'(beats[0].ch));
    else n_pass++;
    for (int k = 0; k < exp_q.size() && k < beats.size(); k++) begin
      n_checks++;
      if (beats[k] !== exp_q[k]) $display("FAIL t5_beat%0d: got %h expected %h", k, beats[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_enable();
    bit ok;
    int n;
    do_reset();
    for (int k = 0; k < 8; k++) push(0, 32'h600 + k);
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL t6_no_grant: got busy=%b expected 0", busy); else n_pass++;
    n_checks++;
    if (pop_cnt != 0) $display("FAIL t6_no_pop: got %0d expected 0", pop_cnt); else n_pass++;
    en = 1'b1;
    n  = 0;
    while (busy !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (busy !== 1'b1 || n > 2) $display("FAIL t6_start_latency: got %0d cycles expected <=2", n); else n_pass++;
    wait_quiet(200, 0, ok);
    n_checks++;
    if (!ok || beats.size() != 8) $display("FAIL t6_burst: got %0d beats expected 8", beats.size()); else n_pass++;
  endtask

  task automatic test_random();
    bit ok;
    int cnt;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      for (int c = 0; c < CH; c++) begin
        cnt = $urandom_range(0, DEPTH);
        for (int k = 0; k < cnt; k++) push(c, $urandom());
      end
      model_expect(1'b0);
      en = 1'b1;
      wait_quiet(2000, 1, ok);
      n_checks++;
      if (!ok) $display("FAIL rnd%0d_norm_timeout: got busy=%b expected idle", it, busy); else n_pass++;
      n_checks++;
      if (beats.size() != exp_q.size()) $display("FAIL rnd%0d_norm_count: got %0d expected %0d", it, beats.size(), exp_q.size());
      else n_pass++;
      for (int k = 0; k < exp_q.size() && k < beats.size(); k++) begin
        n_checks++;
        if (beats[k] !== exp_q[k]) $display("FAIL rnd%0d_norm_beat%0d: got %h expected %h", it, k, beats[k], exp_q[k]);
        else n_pass++;
      end
      beats.delete();
      drain = 1'b1;
      model_expect(1'b1);
      wait_quiet(2000, 1, ok);
      n_checks++;
      if (!ok) $display("FAIL rnd%0d_drain_timeout: got busy=%b expected idle", it, busy); else n_pass++;
      n_checks++;
      if (beats.size() != exp_q.size()) $display("FAIL rnd%0d_drain_count: got %0d expected %0d", it, beats.size(), exp_q.size());
      else n_pass++;
      for (int k = 0; k < exp_q.size() && k < beats.size(); k++) begin
        n_checks++;
        if (beats[k] !== exp_q[k]) $display("FAIL rnd%0d_drain_beat%0d: got %h expected %h", it, k, beats[k], exp_q[k]);
        else n_pass++;
      end
      drain = 1'b0;
    end
  endtask

  task automatic test_protocol();
    n_checks++;
    if (pop_err != 0) $display("FAIL pop_on_empty: got %0d expected 0", pop_err); else n_pass++;
    n_checks++;
    if (multi_err != 0) $display("FAIL multi_pop: got %0d expected 0", multi_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_reset_mid_burst();
    test_enable();
    test_random();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
